// File: rtl/fp_frame_sequencer_if.sv
// Upstream pixel stream handshake for fp_frame_sequencer.
// master drives pixels into the sequencer; slave is the sequencer side.
interface fp_frame_sequencer_if #(
   parameter int DATA_W = 16
);
   logic              s_valid;
   logic              s_ready;
   logic [DATA_W-1:0] s_data;

   modport master (output s_valid, output s_data, input s_ready);
   modport slave  (input s_valid, input s_data, output s_ready);
endinterface

// File: rtl/fp_frame_sequencer.sv
// Buffers a flat pixel stream and replays it as NUM_DIM framed channels
// (header, IMG_H rows of IMG_W pixels) for forward_pass_top.
module fp_frame_sequencer #(
   parameter int DATA_W     = 16,
   parameter int IMG_W      = 32,
   parameter int IMG_H      = 35,
   parameter int NUM_DIM    = 5,
   parameter int FIFO_DEPTH = 64
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   fp_frame_sequencer_if.slave up,
   output logic [DATA_W-1:0] ima,
   output logic              ena_in,
   output logic              frame_start_in,
   output logic              frame_start_dim_in,
   output logic              line_start_in,
   output logic              frame_end_in,
   output logic              frame_end_dim_in,
   output logic              busy,
   output logic              done
);

   localparam int AW    = $clog2(FIFO_DEPTH);
   localparam int CW    = (IMG_W   > 1) ? $clog2(IMG_W)   : 1;
   localparam int RW    = (IMG_H   > 1) ? $clog2(IMG_H)   : 1;
   localparam int DW    = (NUM_DIM > 1) ? $clog2(NUM_DIM) : 1;
   localparam int TOTAL = IMG_W * IMG_H * NUM_DIM;
   localparam int ACW   = $clog2(TOTAL + 1);

   localparam logic [CW-1:0]  COL_LAST  = CW'(IMG_W - 1);
   localparam logic [RW-1:0]  ROW_LAST  = RW'(IMG_H - 1);
   localparam logic [DW-1:0]  DIM_LAST  = DW'(NUM_DIM - 1);
   localparam logic [ACW-1:0] ACC_MAX   = ACW'(TOTAL);
   localparam logic [AW:0]    FIFO_FULL = (AW + 1)'(FIFO_DEPTH);
   localparam logic [AW:0]    PTR_ONE   = (AW + 1)'(1);

   typedef enum logic [1:0] {IDLE, HDR, PIX, FIN} state_t;

   state_t            state;
   logic [CW-1:0]     col;
   logic [RW-1:0]     row;
   logic [DW-1:0]     dim;
   logic [ACW-1:0]    accepted;

   // FIFO pointers carry one extra wrap bit so full and empty are distinct.
   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic [AW:0]       fifo_count;
   logic              fifo_empty;
   logic              fifo_full;
   logic [DATA_W-1:0] rd_data;
   logic              push;
   logic              pop;

   assign fifo_count = wr_ptr - rd_ptr;
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (fifo_count == FIFO_FULL);
   assign rd_data    = mem[rd_ptr[AW-1:0]];

   assign up.s_ready = (state != IDLE) && !fifo_full && (accepted < ACC_MAX);
   assign push       = up.s_valid && up.s_ready;
   assign pop        = (state == PIX) && !fifo_empty;

   // NOTE: storage has no reset; the pointers alone define which words are live.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= up.s_data;
   end

   // NOTE: state registers use <= so every block sees pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // Intake is capped per tensor; the count restarts only on an accepted start.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         accepted <= '0;
      end else if (state == IDLE && start) begin
         accepted <= '0;
      end else if (push) begin
         accepted <= accepted + ACW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state              <= IDLE;
         col                <= '0;
         row                <= '0;
         dim                <= '0;
         ima                <= '0;
         ena_in             <= 1'b0;
         frame_start_in     <= 1'b0;
         frame_start_dim_in <= 1'b0;
         line_start_in      <= 1'b0;
         frame_end_in       <= 1'b0;
         frame_end_dim_in   <= 1'b0;
         busy               <= 1'b0;
         done               <= 1'b0;
      end else begin
         // Flags are single-cycle strobes unless a state re-asserts them.
         ena_in             <= 1'b0;
         frame_start_in     <= 1'b0;
         frame_start_dim_in <= 1'b0;
         line_start_in      <= 1'b0;
         frame_end_in       <= 1'b0;
         frame_end_dim_in   <= 1'b0;
         done               <= 1'b0;

         case (state)
            IDLE: begin
               if (start) begin
                  state <= HDR;
                  busy  <= 1'b1;
                  col   <= '0;
                  row   <= '0;
                  dim   <= '0;
               end
            end

            HDR: begin
               frame_start_in     <= 1'b1;
               line_start_in      <= 1'b1;
               frame_start_dim_in <= (dim == '0);
               state              <= PIX;
            end

            PIX: begin
               if (pop) begin
                  ima    <= rd_data;
                  ena_in <= 1'b1;
                  if (col == COL_LAST) begin
                     col <= '0;
                     if (row == ROW_LAST) begin
                        row              <= '0;
                        frame_end_in     <= 1'b1;
                        frame_end_dim_in <= (dim == DIM_LAST);
                        if (dim == DIM_LAST) begin
                           state <= FIN;
                        end else begin
                           dim   <= dim + DW'(1);
                           state <= HDR;
                        end
                     end else begin
                        row           <= row + RW'(1);
                        line_start_in <= 1'b1;
                     end
                  end else begin
                     col <= col + CW'(1);
                  end
               end
            end

            FIN: begin
               done  <= 1'b1;
               busy  <= 1'b0;
               dim   <= '0;
               state <= IDLE;
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fp_frame_sequencer.md
Name: fp_frame_sequencer

Overview:
- Sits directly upstream of forward_pass_top.
- Accepts a flat pixel stream over a valid/ready handshake and buffers it in a small FIFO.
- Emits the framing protocol forward_pass_top consumes: ima, ena_in, frame_start_in, frame_start_dim_in, line_start_in, frame_end_in, frame_end_dim_in.
- One start pulse sequences a full tensor of NUM_DIM channel frames, each IMG_H rows by IMG_W pixels.

Parameters:
DATA_W, 16, pixel width (drives ima)
IMG_W, 32, pixels per row
IMG_H, 35, rows per frame
NUM_DIM, 5, channel frames per tensor
FIFO_DEPTH, 64, input buffer depth in words (power of 2, >= 2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle request to stream one tensor; ignored unless idle
s_valid  in  1  upstream pixel valid
s_ready  out  1  block accepts a pixel this cycle
s_data  in  DATA_W  upstream pixel
ima  out  DATA_W  pixel to forward_pass_top
ena_in  out  1  ima is a valid pixel this cycle
frame_start_in  out  1  channel header cycle
frame_start_dim_in  out  1  header cycle of the first channel (dim 0)
line_start_in  out  1  row marker (see Behaviour)
frame_end_in  out  1  last pixel of a channel
frame_end_dim_in  out  1  last pixel of the last channel
busy  out  1  tensor in progress
done  out  1  one-cycle pulse after the tensor completes

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; ima=0.
  - State IDLE; col, row, dim and accept counters 0; FIFO emptied.
  - Reset mid-tensor aborts immediately; no partial flags survive.
- All downstream outputs and done/busy are registered. s_ready is combinational: (state != IDLE) && !fifo_full && (accepted < IMG_W*IMG_H*NUM_DIM).
- FIFO: first-word-fall-through. A word written at edge E can be popped at edge E+1. Simultaneous push and pop when full or empty is legal and keeps the count consistent.
- States: IDLE, HDR, PIX, FIN.
  - IDLE: start=1 at edge E0 -> HDR; busy=1 from E0.
  - HDR: exactly one cycle; no pop.
    - Registered outputs: frame_start_in=1, line_start_in=1, frame_start_dim_in=(dim==0), ena_in=0, other flags 0.
    - -> PIX.
  - PIX, FIFO non-empty: pop and register ima=data, ena_in=1.
    - line_start_in = (col==IMG_W-1 && row<IMG_H-1).
    - frame_end_in = (col==IMG_W-1 && row==IMG_H-1).
    - frame_end_dim_in = frame_end_in && dim==NUM_DIM-1.
    - col wraps at IMG_W-1 and increments row; row clears at end of frame.
  - PIX, FIFO empty: bubble. ena_in=0, all flags 0, ima holds, counters hold.
  - End of frame: after the last pixel, if dim<NUM_DIM-1 then dim++ -> HDR; else -> FIN.
  - FIN: done=1 for one cycle, busy=0, dim cleared -> IDLE.
- Timing with s_valid held high from E0:
  - Header in cycle [E1,E2).
  - Pixel k of channel 0 has ena_in=1 in [E2+k, E3+k); no bubbles.
  - Each later header immediately follows the previous frame_end_in cycle.
  - done follows the frame_end_dim_in cycle by one cycle.
- Accept counter caps intake at exactly IMG_W*IMG_H*NUM_DIM words. Extra upstream words are never accepted.
- start while busy is ignored.
- start coincident with the FIN cycle is ignored; it is accepted only from IDLE.

Test Plan:
- Reset, then start with s_valid=1 and s_data=0,1,2,... -> header at cycle 1 with frame_start_dim_in=1.
  - Pixel 0..1119 on consecutive cycles.
  - line_start_in on pixels 31,63,...,1087 (34 pulses).
  - frame_end_in on pixel 1119; five frames total.
  - frame_end_dim_in only on the fifth frame's last pixel; done one cycle later.
- Random s_valid (~50%) -> ena_in count per frame is exactly 1120 and ima sequence is in-order.
  - Bubbles show all flags 0.
  - Header/flag positions are identical to the gapless case.
- Upstream offers 5700 words -> exactly 5600 accepted; s_ready=0 after the cap; done pulses once.
- start pulsed again mid-tensor, and on the FIN cycle -> no effect on counters or outputs; busy drops once.
- rst_n=0 mid-row (frame 2, row 10) -> all outputs 0 asynchronously, FIFO empty.
  - After release, a new start produces a header with frame_start_dim_in=1 and ima restarting from the new stream.
- Hold s_valid=0 for 100 cycles after the header -> s_ready=1, ena_in=0 throughout.
  - Then s_valid=1 -> first pixel appears 2 cycles after the first accepted word.
